// File: rtl/ise_result_sink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ise_result_sink_pkg                                                        |
// | Shared widths, colour codes and FSM encodings for the result sink.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ise_result_sink_pkg;

  localparam int N_IMG_DEF = 32;
  localparam int IDX_W_DEF = 5;
  localparam int CLR_W_DEF = 2;
  localparam int PTR_W     = 6;
  localparam int CNT_W     = 6;

  localparam logic [1:0] CLR_RED   = 2'd0;
  localparam logic [1:0] CLR_GREEN = 2'd1;
  localparam logic [1:0] CLR_BLUE  = 2'd2;
  localparam logic [1:0] CLR_ILL   = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_DRAIN   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ise_result_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ise_result_sink_if                                                         |
// | Result strobe from the sorting engine plus the valid/ready drain port.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ise_result_sink_if #(
  parameter int IDX_W = 5,
  parameter int CLR_W = 2
);
  logic                   out_valid;
  logic [CLR_W-1:0]       color_index;
  logic [IDX_W-1:0]       image_out_index;
  logic                   drain_ready;
  logic                   drain_valid;
  logic [CLR_W+IDX_W-1:0] drain_data;

  modport master (
    output out_valid, color_index, image_out_index, drain_ready,
    input  drain_valid, drain_data
  );

  modport slave (
    input  out_valid, color_index, image_out_index, drain_ready,
    output drain_valid, drain_data
  );
endinterface
`default_nettype wire

// File: rtl/ise_result_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ise_result_buf                                                             |
// | N_IMG-entry in-order register array with write/read pointers.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ise_result_buf #(
  parameter int N_IMG  = 32,
  parameter int DATA_W = 7,
  parameter int PTR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_adv,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [N_IMG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Contents are deliberately left out of reset; pointers gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IMG; i++) begin
      if (wr_en && !clr && (wr_ptr == PTR_W'(i))) mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_IMG; i++) begin
      if (rd_ptr == PTR_W'(i)) rd_data = mem[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ise_result_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ise_result_sink                                                            |
// | Captures sorted results, tallies colours, checks order, drains a frame.    |
// | Optional duplicate-index check: define ISE_SINK_DUP_CHK_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ise_result_sink
  import ise_result_sink_pkg::*;
#(
  parameter int N_IMG = N_IMG_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CLR_W = CLR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  ise_result_sink_if.slave bus,
  output logic             done,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_b,
  output logic             order_err,
  output logic             cls_err,
  output logic             ovf_err,
  output logic             dup_err
);

  localparam int DATA_W = CLR_W + IDX_W;

  state_t            state;
  state_t            state_nx;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic [CLR_W-1:0]  last_clr;
  logic              capture;
  logic              accept;
  logic              last_wr;
  logic              last_rd;
  logic              stray;

  // start wins over everything, so a coincident strobe is neither stored nor flagged.
  assign capture = (state == ST_COLLECT) && bus.out_valid && !start;
  assign accept  = (state == ST_DRAIN) && bus.drain_ready && !start;
  assign last_wr = capture && (wr_ptr == PTR_W'(N_IMG - 1));
  assign last_rd = accept && (rd_ptr == PTR_W'(N_IMG - 1));
  assign stray   = bus.out_valid && !start && (state != ST_COLLECT);

  ise_result_buf #(
    .N_IMG  (N_IMG),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .wr_en   (capture),
    .wr_data ({bus.color_index, bus.image_out_index}),
    .rd_adv  (accept),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_COLLECT;
    end else begin
      case (state)
        ST_IDLE:    state_nx = ST_IDLE;
        ST_COLLECT: if (last_wr) state_nx = ST_DRAIN;
        ST_DRAIN:   if (last_rd) state_nx = ST_IDLE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done            = 1'b0;
    bus.drain_valid = 1'b0;
    bus.drain_data  = '0;
    if (state == ST_DRAIN) begin
      done            = 1'b1;
      bus.drain_valid = 1'b1;
      bus.drain_data  = rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      order_err <= 1'b0;
      cls_err   <= 1'b0;
      ovf_err   <= 1'b0;
      last_clr  <= '0;
    end else if (start) begin
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      order_err <= 1'b0;
      cls_err   <= 1'b0;
      ovf_err   <= 1'b0;
      last_clr  <= '0;
    end else begin
      if (stray) ovf_err <= 1'b1;
      if (capture) begin
        case (bus.color_index)
          CLR_W'(CLR_RED):   cnt_r <= cnt_r + CNT_W'(1);
          CLR_W'(CLR_GREEN): cnt_g <= cnt_g + CNT_W'(1);
          CLR_W'(CLR_BLUE):  cnt_b <= cnt_b + CNT_W'(1);
          default:           cls_err <= 1'b1;
        endcase
        // wr_ptr of zero means this is the first result of the frame.
        if ((wr_ptr != '0) && (bus.color_index < last_clr)) order_err <= 1'b1;
        last_clr <= bus.color_index;
      end
    end
  end

`ifdef ISE_SINK_DUP_CHK_EN
  logic [(1<<IDX_W)-1:0] seen;
  logic                  dup_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen     <= '0;
      dup_flag <= 1'b0;
    end else if (start) begin
      seen     <= '0;
      dup_flag <= 1'b0;
    end else if (capture) begin
      if (seen[bus.image_out_index]) dup_flag <= 1'b1;
      seen[bus.image_out_index] <= 1'b1;
    end
  end

  assign dup_err = dup_flag;
`else
  assign dup_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ise_result_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ise_result_sink                                                         |
// | Randomised and directed frames checked against a queue-based model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ise_result_sink;

  localparam int N  = 32;
  localparam int IW = 5;
  localparam int CW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [5:0] cnt_r, cnt_g, cnt_b;
  logic       order_err, cls_err, ovf_err, dup_err;

  ise_result_sink_if #(.IDX_W(IW), .CLR_W(CW)) bus ();

  ise_result_sink #(.N_IMG(N), .IDX_W(IW), .CLR_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .done      (done),
    .cnt_r     (cnt_r),
    .cnt_g     (cnt_g),
    .cnt_b     (cnt_b),
    .order_err (order_err),
    .cls_err   (cls_err),
    .ovf_err   (ovf_err),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 collecting, 2 draining.
  int         m_mode;
  logic [6:0] cap[$];
  int         m_rd;
  int         m_cnt[3];
  bit         m_ord, m_cls, m_ovf, m_dup;
  bit         seen[32];

  logic [1:0] fc[N];
  logic [4:0] fi[N];

  task automatic model_clear();
    cap.delete();
    m_rd = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_ord = 0; m_cls = 0; m_ovf = 0; m_dup = 0;
    for (int i = 0; i < 32; i++) seen[i] = 0;
  endtask

  task automatic model_step(input bit st, input bit ov, input logic [1:0] c,
                            input logic [4:0] idx, input bit rdy);
    logic [6:0] last;
    if (st) begin
      model_clear();
      m_mode = 1;
    end else if (m_mode == 0) begin
      if (ov) m_ovf = 1;
    end else if (m_mode == 1) begin
      if (ov) begin
        if (cap.size() > 0) begin
          last = cap[cap.size()-1];
          if (c < last[6:5]) m_ord = 1;
        end
        if (c == 2'd3) m_cls = 1;
        else m_cnt[c]++;
        if (seen[idx]) m_dup = 1;
        seen[idx] = 1;
        cap.push_back({c, idx});
        if (cap.size() == N) m_mode = 2;
      end
    end else begin
      if (ov) m_ovf = 1;
      if (rdy) begin
        m_rd++;
        if (m_rd == N) m_mode = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit         exp_dup;
    logic [6:0] exp_data;
`ifdef ISE_SINK_DUP_CHK_EN
    exp_dup = m_dup;
`else
    exp_dup = 1'b0;
`endif
    exp_data = (m_mode == 2) ? cap[m_rd] : 7'd0;
    check("done",        32'(done),            32'(m_mode == 2));
    check("drain_valid", 32'(bus.drain_valid), 32'(m_mode == 2));
    check("drain_data",  32'(bus.drain_data),  32'(exp_data));
    check("cnt_r",       32'(cnt_r),           32'(m_cnt[0]));
    check("cnt_g",       32'(cnt_g),           32'(m_cnt[1]));
    check("cnt_b",       32'(cnt_b),           32'(m_cnt[2]));
    check("order_err",   32'(order_err),       32'(m_ord));
    check("cls_err",     32'(cls_err),         32'(m_cls));
    check("ovf_err",     32'(ovf_err),         32'(m_ovf));
    check("dup_err",     32'(dup_err),         32'(exp_dup));
  endtask

  task automatic cyc(input bit st, input bit ov, input logic [1:0] c,
                     input logic [4:0] idx, input bit rdy);
    start               = st;
    bus.out_valid       = ov;
    bus.color_index     = c;
    bus.image_out_index = idx;
    bus.drain_ready     = rdy;
    @(posedge clk);
    #1;
    model_step(st, ov, c, idx, rdy);
    compare_all();
  endtask

  task automatic run_frame(input bit gaps);
    cyc(1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
      cyc(1'b0, 1'b1, fc[i], fi[i], 1'($urandom_range(0, 1)));
    end
  endtask

  // mode 0: always ready, 1: ready toggles 0/1, 2: random ready.
  task automatic drain_all(input int mode, output int dv_cycles);
    bit rdy;
    dv_cycles = 0;
    for (int k = 0; k < 1000 && m_mode == 2; k++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(k % 2) : 1'($urandom_range(0, 1));
      if (bus.drain_valid) dv_cycles++;
      cyc(1'b0, 1'b0, 2'd0, 5'd0, rdy);
    end
    cyc(1'b0, 1'b0, 2'd0, 5'd0, 1'b1);
    check("drain_idle", 32'(bus.drain_valid), 32'd0);
  endtask

  task automatic ordered_frame();
    for (int i = 0; i < N; i++) begin
      fc[i] = (i < 10) ? 2'd0 : (i < 22) ? 2'd1 : 2'd2;
      fi[i] = 5'(i);
    end
  endtask

  task automatic random_frame(input bit legal);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (legal) begin
        if ($urandom_range(0, 7) == 0 && c < 2'd2) c = c + 2'd1;
        fc[i] = c;
      end else begin
        fc[i] = 2'($urandom_range(0, 3));
      end
      fi[i] = 5'($urandom_range(0, 31));
    end
  endtask

  int n;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus.out_valid = 1'b0;
    bus.color_index = '0;
    bus.image_out_index = '0;
    bus.drain_ready = 1'b0;
    m_mode = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // Stray strobe while idle.
    cyc(1'b0, 1'b1, 2'd1, 5'd3, 1'b0);
    check("idle_ovf", 32'(ovf_err), 32'd1);

    // Ordered frame, back-to-back, always-ready drain.
    ordered_frame();
    run_frame(1'b0);
    check("ord_done", 32'(done), 32'd1);
    check("ord_cnt_r", 32'(cnt_r), 32'd10);
    check("ord_cnt_g", 32'(cnt_g), 32'd12);
    check("ord_cnt_b", 32'(cnt_b), 32'd10);
    check("ord_errs", 32'({order_err, cls_err, ovf_err, dup_err}), 32'd0);
    drain_all(0, n);
    check("ord_drain_cycles", 32'(n), 32'd32);

    // Order violation: green then red.
    ordered_frame();
    fc[0] = 2'd1; fi[0] = 5'd3;
    fc[1] = 2'd0; fi[1] = 5'd4;
    for (int i = 2; i < N; i++) fc[i] = 2'd2;
    run_frame(1'b0);
    check("ordv_err", 32'(order_err), 32'd1);
    drain_all(2, n);
    check("ordv_sticky", 32'(order_err), 32'd1);

    // Toggling backpressure.
    ordered_frame();
    run_frame(1'b0);
    drain_all(1, n);
    check("bp_drain_cycles", 32'(n), 32'd64);

    // Illegal colour on the last result, then a strobe during drain.
    ordered_frame();
    fc[N-1] = 2'd3;
    run_frame(1'b0);
    check("cls_err", 32'(cls_err), 32'd1);
    check("cls_sum", 32'(cnt_r) + 32'(cnt_g) + 32'(cnt_b), 32'd31);
    cyc(1'b0, 1'b0, 2'd0, 5'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 5'd9, 1'b0);
    check("drain_ovf", 32'(ovf_err), 32'd1);
    drain_all(0, n);

    // start coincident with the 5th strobe.
    ordered_frame();
    cyc(1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, fc[i], fi[i], 1'b0);
    cyc(1'b1, 1'b1, 2'd2, 5'd9, 1'b0);
    check("restart_sum", 32'(cnt_r) + 32'(cnt_g) + 32'(cnt_b), 32'd0);
    for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, fc[i], fi[i], 1'b0);
    drain_all(0, n);
    check("restart_drain_cycles", 32'(n), 32'd32);

    // Duplicate index 7.
    ordered_frame();
    fi[8] = 5'd7;
    run_frame(1'b0);
`ifdef ISE_SINK_DUP_CHK_EN
    check("dup_seen", 32'(dup_err), 32'd1);
`else
    check("dup_off", 32'(dup_err), 32'd0);
`endif
    drain_all(0, n);

    // Asynchronous reset in the middle of a drain.
    random_frame(1'b1);
    run_frame(1'b1);
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 5'd0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    m_mode = 0;
    model_clear();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'b0);
      random_frame(f % 3 != 0);
      run_frame(1'b1);
      drain_all(2, n);
      check("rnd_drain_cycles", 32'(n) >= 32'd32 ? 32'd1 : 32'd0, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ise_result_sink.md
Name: ise_result_sink

Overview:
- Sits directly downstream of the image sorting engine.
- Captures each classified result ({color_index, image_out_index}) on out_valid into an in-order buffer and keeps per-colour tallies.
- Checks that results arrive grouped in non-decreasing colour order.
- Once N_IMG results have arrived, replays them over a valid/ready drain port to the bench or host.

Parameters:
N_IMG, 32, number of results per frame of images (1..32)
IDX_W, 5, width of image_out_index
CLR_W, 2, width of color_index (0=red, 1=green, 2=blue, 3=illegal)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (named reset as across the codebase; low = reset asserted)
start  in  1  one-cycle pulse; clears all state and arms collection
out_valid  in  1  result strobe from the sorting engine
color_index  in  CLR_W  colour class of the current result
image_out_index  in  IDX_W  image number of the current result
drain_ready  in  1  consumer accepts drain_data this cycle
drain_valid  out  1  drain_data holds a buffered result
drain_data  out  CLR_W+IDX_W  {color, index} of the entry at the read pointer
done  out  1  high while in DRAIN (all N_IMG results captured)
cnt_r, cnt_g, cnt_b  out  6 each  results received per colour
order_err  out  1  sticky: colour decreased versus the previous result
cls_err  out  1  sticky: color_index==3 received
ovf_err  out  1  sticky: out_valid while not collecting and armed
dup_err  out  1  sticky duplicate-index flag (see Optional Feature)

Behaviour:
- Reset (reset low, async):
  - State IDLE, all pointers 0.
  - All counters 0, all err flags 0.
  - drain_valid=0, drain_data=0, done=0.
- Storage: N_IMG x (CLR_W+IDX_W) register array; wr_ptr and rd_ptr are 6 bits.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - out_valid is ignored and sets ovf_err.
  - start → COLLECT with ptrs, counters, flags and last_clr cleared.
- COLLECT, on out_valid:
  - mem[wr_ptr] <= {color_index, image_out_index}; wr_ptr++.
  - Increment cnt_r, cnt_g or cnt_b by colour; colour 3 sets cls_err and increments no tally.
  - If a previous result exists and color_index < last_clr, set order_err.
  - last_clr <= color_index.
  - When the write makes wr_ptr == N_IMG, go to DRAIN on the next edge. done and drain_valid rise exactly 1 cycle after the final out_valid.
- DRAIN:
  - drain_valid=1, drain_data=mem[rd_ptr], read combinationally from the registered pointer.
  - drain_valid && drain_ready → rd_ptr++.
  - Acceptance of entry N_IMG-1 → IDLE; done and drain_valid fall the next cycle.
  - drain_data must hold stable while drain_valid && !drain_ready.
  - out_valid in DRAIN sets ovf_err; data is dropped and the buffer is not modified.
- Counters and err flags persist through DRAIN and IDLE until the next start or reset.
- start has priority in every state:
  - Any start → full clear, enter COLLECT.
  - A same-cycle out_valid is dropped; it is not stored and not flagged.
  - start during DRAIN aborts the drain.
- Reset mid-operation: immediate return to the reset state; the buffer contents need not be cleared.
- Throughput: one result accepted per cycle; back-to-back out_valid supported.
- Counters saturate naturally: they cannot exceed N_IMG ≤ 32, which fits in 6 bits.

Optional Feature:
- Macro: ISE_SINK_DUP_CHK_EN.
- Defined:
  - A 2^IDX_W-bit seen mask is cleared on start.
  - On each COLLECT capture, if seen[image_out_index] is already set, set dup_err (sticky); then set the bit.
  - The result is still stored.
- Undefined: no mask is built; dup_err is tied to 0.

Decomposition:
- Shared package: colour enumeration constants (CLR_RED=0, CLR_GREEN=1, CLR_BLUE=2, CLR_ILL=3), FSM state encodings, and widths IDX_W/CLR_W/N_IMG defaults.
- One natural sub-module: ise_result_buf, the N_IMG-entry write-pointer/read-pointer register array with write-enable and combinational read.
- FSM, tallies and checks stay in ise_result_sink.

Test Plan:
- Ordered frame: start, then 32 back-to-back out_valid (10 red idx 0-9, 12 green idx 10-21, 10 blue idx 22-31), drain_ready=1:
  - done high 1 cycle after the last strobe; cnt_r=10, cnt_g=12, cnt_b=10.
  - All err flags 0.
  - Drain emits the 32 entries in capture order over 32 cycles, then drain_valid=0.
- Order violation: green idx 3, then red idx 4 → order_err=1 after the second strobe, sticky through DRAIN; both entries still stored.
- Drain backpressure: drain_ready toggles 0/1 every cycle → each entry is held stable while ready=0; 32 entries in 64 cycles; no loss or repeat.
- Illegal/overflow cases:
  - color 3 on one result → cls_err=1, tallies sum to 31.
  - One extra out_valid during DRAIN → ovf_err=1, drain data unchanged.
- Restart and reset:
  - start asserted on the same cycle as the 5th out_valid → counters 0, that result dropped, wr_ptr 0.
  - reset low during DRAIN → all outputs 0 asynchronously, state IDLE.
- Duplicates with ISE_SINK_DUP_CHK_EN defined: idx 7 sent twice → dup_err=1.
- Duplicates with the macro undefined: same stimulus → dup_err remains 0.
